// File: rtl/perf_counter_bank_if.sv
// Register-port bundle for the performance-counter bank.
// The master issues one access per cycle with cfg_req high; the slave
// answers on the following cycle with cfg_ack and, for reads, cfg_rdata.
interface perf_counter_bank_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 cfg_req;
  logic                 cfg_we;
  logic [7:0]           cfg_addr;
  logic [CNT_WIDTH-1:0] cfg_wdata;
  logic [CNT_WIDTH-1:0] cfg_rdata;
  logic                 cfg_ack;

  modport master (
    output cfg_req, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rdata, cfg_ack
  );

  modport slave (
    input  cfg_req, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rdata, cfg_ack
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Per-core performance-counter bank: NUM_EVENTS counters with multi-bit
// increments, wrap or saturate on carry-out, atomic snapshot into shadow
// registers, per-channel overflow status and a registered overflow interrupt.
// Software reaches everything through the request/ack register port.
module perf_counter_bank #(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int INC_WIDTH  = 2,
  parameter int SATURATE   = 0,
  parameter int CORE_ID    = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0] events,
  input  logic                            snapshot,
  perf_counter_bank_if.slave              cfg,
  output logic                            ovf_irq
);

  localparam logic [7:0] ADDR_SHADOW  = 8'h20;
  localparam logic [7:0] ADDR_CTRL    = 8'h40;
  localparam logic [7:0] ADDR_OVF     = 8'h41;
  localparam logic [7:0] ADDR_IRQ_EN  = 8'h42;
  localparam logic [7:0] ADDR_CORE_ID = 8'h43;

  // Per-channel bit vectors (OVF_STATUS, IRQ_EN) are mapped onto the data
  // word bit-for-bit; channels beyond the data width have no register bit.
  localparam int MAP_BITS = (NUM_EVENTS < CNT_WIDTH) ? NUM_EVENTS : CNT_WIDTH;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0]  cnt_q    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  cnt_d    [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  shadow_q [NUM_EVENTS];
  logic [CNT_WIDTH:0]    sum      [NUM_EVENTS];
  logic                  freeze_q;
  logic                  freeze_d;
  logic [NUM_EVENTS-1:0] ovf_q;
  logic [NUM_EVENTS-1:0] ovf_d;
  logic [NUM_EVENTS-1:0] ovf_set;
  logic [NUM_EVENTS-1:0] w1c_mask;
  logic [NUM_EVENTS-1:0] irq_en_q;
  logic [NUM_EVENTS-1:0] irq_en_d;
  logic [CNT_WIDTH-1:0]  read_val;

  logic wr_access;
  logic rd_access;
  logic ctrl_wr;
  logic clear_all;
  logic count_en;

  assign wr_access = cfg.cfg_req & cfg.cfg_we;
  assign rd_access = cfg.cfg_req & ~cfg.cfg_we;
  assign ctrl_wr   = wr_access && (cfg.cfg_addr == ADDR_CTRL);
  assign clear_all = ctrl_wr && cfg.cfg_wdata[1];
  assign count_en  = enable & ~freeze_q;

  // Next counter values: clear_all beats a CPU write, which beats counting;
  // a carry out of the widened sum flags overflow and wraps or saturates.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      sum[i]   = {1'b0, cnt_q[i]} + (CNT_WIDTH+1)'(events[i*INC_WIDTH +: INC_WIDTH]);
      cnt_d[i] = cnt_q[i];
      if (clear_all) begin
        cnt_d[i] = '0;
      end else if (wr_access && (cfg.cfg_addr == 8'(i))) begin
        cnt_d[i] = cfg.cfg_wdata;
      end else if (count_en) begin
        ovf_set[i] = sum[i][CNT_WIDTH];
        if (sum[i][CNT_WIDTH] && (SATURATE != 0)) begin
          cnt_d[i] = CNT_MAX;
        end else begin
          cnt_d[i] = sum[i][CNT_WIDTH-1:0];
        end
      end
    end
  end

  // Control, status and interrupt-enable updates; a fresh overflow wins over
  // a write-1-to-clear on the same bit, and clear_all wipes the status.
  always_comb begin
    w1c_mask = '0;
    irq_en_d = irq_en_q;
    freeze_d = freeze_q;
    if (wr_access && (cfg.cfg_addr == ADDR_OVF)) begin
      for (int i = 0; i < MAP_BITS; i++) w1c_mask[i] = cfg.cfg_wdata[i];
    end
    if (wr_access && (cfg.cfg_addr == ADDR_IRQ_EN)) begin
      for (int i = 0; i < MAP_BITS; i++) irq_en_d[i] = cfg.cfg_wdata[i];
    end
    if (ctrl_wr) begin
      freeze_d = cfg.cfg_wdata[0];
    end
    if (clear_all) begin
      ovf_d = '0;
    end else begin
      ovf_d = (ovf_q & ~w1c_mask) | ovf_set;
    end
  end

  // Read multiplexer over the register map; anything unmapped reads as zero.
  always_comb begin
    read_val = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (cfg.cfg_addr == 8'(i)) read_val = cnt_q[i];
      if (cfg.cfg_addr == ADDR_SHADOW + 8'(i)) read_val = shadow_q[i];
    end
    case (cfg.cfg_addr)
      ADDR_CTRL:    read_val[0] = freeze_q;
      ADDR_OVF:     for (int i = 0; i < MAP_BITS; i++) read_val[i] = ovf_q[i];
      ADDR_IRQ_EN:  for (int i = 0; i < MAP_BITS; i++) read_val[i] = irq_en_q[i];
      ADDR_CORE_ID: read_val = CNT_WIDTH'(CORE_ID);
      default:      ;
    endcase
  end

  // State registers; the snapshot copies pre-edge counts so it sees values
  // from before any clear or write landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      freeze_q  <= 1'b0;
      ovf_q     <= '0;
      irq_en_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (snapshot) shadow_q[i] <= cnt_q[i];
      end
      freeze_q <= freeze_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
    end
  end

  // Register-port response and interrupt: one cycle behind the request and
  // the status/enable pair respectively; rdata is zero whenever ack is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg.cfg_ack   <= 1'b0;
      cfg.cfg_rdata <= '0;
      ovf_irq       <= 1'b0;
    end else begin
      cfg.cfg_ack   <= cfg.cfg_req;
      cfg.cfg_rdata <= rd_access ? read_val : '0;
      ovf_irq       <= |(ovf_q & irq_en_q);
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: directed scenarios plus a
// randomized phase, all checked against a behavioural model of the bank.
module tb_perf_counter_bank;

  localparam int NE      = 8;
  localparam int CW      = 32;
  localparam int IW      = 2;
  localparam int TB_SAT  = 0;
  localparam int TB_CORE = 5;
  localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [NE*IW-1:0]  events;
  logic              snapshot;
  logic              ovf_irq;

  perf_counter_bank_if #(.CNT_WIDTH(CW)) cfg_bus ();

  perf_counter_bank #(
    .NUM_EVENTS(NE), .CNT_WIDTH(CW), .INC_WIDTH(IW),
    .SATURATE(TB_SAT), .CORE_ID(TB_CORE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .events(events),
    .snapshot(snapshot), .cfg(cfg_bus.slave), .ovf_irq(ovf_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    check_count = 0;
  int    pass_count  = 0;
  string phase       = "reset";

  // Reference model state, held as plain integers.
  longint unsigned m_cnt    [NE];
  longint unsigned m_shadow [NE];
  bit              m_freeze;
  bit [NE-1:0]     m_ovf;
  bit [NE-1:0]     m_irqen;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s/%s: got 0x%0h, expected 0x%0h", phase, tag, observed, expected);
  endtask

  task automatic resetModel();
    for (int i = 0; i < NE; i++) begin
      m_cnt[i]    = 0;
      m_shadow[i] = 0;
    end
    m_freeze = 0;
    m_ovf    = '0;
    m_irqen  = '0;
  endtask

  function automatic longint unsigned modelRead(input logic [7:0] a);
    if (a < 8'(NE)) return m_cnt[a];
    if (a >= 8'h20 && a < 8'h20 + 8'(NE)) return m_shadow[a - 8'h20];
    case (a)
      8'h40:   return longint'(m_freeze);
      8'h41:   return longint'(m_ovf);
      8'h42:   return longint'(m_irqen);
      8'h43:   return TB_CORE;
      default: return 0;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model by one edge, then check
  // ack, read data and interrupt just after that edge.
  task automatic applyStimulus(input bit en, input logic [NE*IW-1:0] ev,
                               input bit snap, input bit req, input bit we,
                               input logic [7:0] addr, input logic [CW-1:0] wdata);
    longint unsigned exp_rdata, s, new_cnt[NE];
    bit              exp_ack, exp_irq, wr, clr;
    bit [NE-1:0]     new_ovf;
    @(negedge clk);
    enable            = en;
    events            = ev;
    snapshot          = snap;
    cfg_bus.cfg_req   = req;
    cfg_bus.cfg_we    = we;
    cfg_bus.cfg_addr  = addr;
    cfg_bus.cfg_wdata = wdata;

    exp_ack   = req;
    exp_rdata = (req && !we) ? modelRead(addr) : 0;
    exp_irq   = |(m_ovf & m_irqen);

    wr  = req && we;
    clr = wr && addr == 8'h40 && wdata[1];
    new_ovf = m_ovf;
    if (wr && addr == 8'h41) new_ovf = new_ovf & ~wdata[NE-1:0];
    for (int i = 0; i < NE; i++) begin
      new_cnt[i] = m_cnt[i];
      if (clr) new_cnt[i] = 0;
      else if (wr && addr == 8'(i)) new_cnt[i] = wdata;
      else if (en && !m_freeze) begin
        s = m_cnt[i] + ev[i*IW +: IW];
        if (s > MAXV) begin
          new_ovf[i] = 1'b1;
          new_cnt[i] = (TB_SAT != 0) ? MAXV : s - (MAXV + 1);
        end else new_cnt[i] = s;
      end
    end
    if (clr) new_ovf = '0;
    for (int i = 0; i < NE; i++) begin
      if (snap) m_shadow[i] = m_cnt[i];
      m_cnt[i] = new_cnt[i];
    end
    m_ovf = new_ovf;
    if (wr && addr == 8'h40) m_freeze = wdata[0];
    if (wr && addr == 8'h42) m_irqen = wdata[NE-1:0];

    @(posedge clk);
    #1;
    checkOutput("ack", 64'(cfg_bus.cfg_ack), 64'(exp_ack));
    checkOutput("rdata", 64'(cfg_bus.cfg_rdata), exp_rdata);
    checkOutput("irq", 64'(ovf_irq), 64'(exp_irq));
  endtask

  task automatic doRead(input logic [7:0] addr, output logic [CW-1:0] value);
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 1'b0, addr, '0);
    value = cfg_bus.cfg_rdata;
  endtask

  task automatic doWrite(input logic [7:0] addr, input logic [CW-1:0] data);
    applyStimulus(1'b1, '0, 1'b0, 1'b1, 1'b1, addr, data);
  endtask

  initial begin
    logic [CW-1:0] rv;
    logic [7:0]    ra;
    logic [CW-1:0] rw;
    rst_n             = 1'b0;
    enable            = 1'b0;
    events            = '0;
    snapshot          = 1'b0;
    cfg_bus.cfg_req   = 1'b0;
    cfg_bus.cfg_we    = 1'b0;
    cfg_bus.cfg_addr  = '0;
    cfg_bus.cfg_wdata = '0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("ack", 64'(cfg_bus.cfg_ack), 64'd0);
    checkOutput("rdata", 64'(cfg_bus.cfg_rdata), 64'd0);
    checkOutput("irq", 64'(ovf_irq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    phase = "count";
    repeat (10) applyStimulus(1'b1, 16'h000D, 1'b0, 1'b0, 1'b0, '0, '0);
    doRead(8'h00, rv); checkOutput("cnt0", 64'(rv), 64'd10);
    doRead(8'h01, rv); checkOutput("cnt1", 64'(rv), 64'd30);

    phase = "overflow";
    doWrite(8'h02, 32'hFFFF_FFFE);
    repeat (3) applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, '0, '0);
    doRead(8'h02, rv); checkOutput("cnt2", 64'(rv), (TB_SAT != 0) ? MAXV : 64'd1);
    doRead(8'h41, rv); checkOutput("ovf", 64'(rv), 64'h4);

    phase = "irq";
    doWrite(8'h42, 32'h4);
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("irq_set", 64'(ovf_irq), 64'd1);
    doWrite(8'h41, 32'h4);
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("irq_clr", 64'(ovf_irq), 64'd0);

    phase = "snapshot";
    doWrite(8'h00, 32'd100);
    applyStimulus(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, '0, '0);
    doRead(8'h20, rv); checkOutput("shadow0", 64'(rv), 64'd100);
    doRead(8'h00, rv); checkOutput("cnt0", 64'(rv), 64'd101);
    doRead(8'h20, rv); checkOutput("shadow0_again", 64'(rv), 64'd100);

    phase = "clear_all";
    doWrite(8'h03, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, '0, '0);
    doWrite(8'h00, 32'd55);
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 8'h40, 32'h2);
    doRead(8'h00, rv); checkOutput("cnt0", 64'(rv), 64'd0);
    doRead(8'h03, rv); checkOutput("cnt3", 64'(rv), 64'd0);
    doRead(8'h41, rv); checkOutput("ovf", 64'(rv), 64'd0);
    doRead(8'h20, rv); checkOutput("shadow0_kept", 64'(rv), 64'd100);

    phase = "freeze";
    repeat (3) applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, '0, '0);
    doWrite(8'h40, 32'h1);
    repeat (5) applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, '0, '0);
    doRead(8'h01, rv); checkOutput("cnt1_frozen", 64'(rv), 64'd9);
    doRead(8'h43, rv); checkOutput("core_id", 64'(rv), 64'(TB_CORE));
    doRead(8'h7F, rv); checkOutput("unmapped", 64'(rv), 64'd0);
    checkOutput("unmapped_ack", 64'(cfg_bus.cfg_ack), 64'd1);
    doWrite(8'h40, 32'h0);

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0:       ra = 8'($urandom_range(0, 9));
        1:       ra = 8'h20 + 8'($urandom_range(0, 8));
        2, 3:    ra = 8'h40 + 8'($urandom_range(0, 3));
        4:       ra = 8'($urandom_range(0, 7));
        default: ra = 8'($urandom);
      endcase
      if (ra == 8'h40) rw = 32'($urandom_range(0, 3));
      else if ($urandom_range(0, 2) == 0) rw = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else rw = $urandom;
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, ra, rw);
    end

    phase = "reset_mid_access";
    doWrite(8'h00, 32'd12);
    @(negedge clk);
    cfg_bus.cfg_req   = 1'b1;
    cfg_bus.cfg_we    = 1'b1;
    cfg_bus.cfg_addr  = 8'h00;
    cfg_bus.cfg_wdata = 32'd77;
    #2 rst_n = 1'b0;
    resetModel();
    @(posedge clk);
    #1;
    checkOutput("ack_dropped", 64'(cfg_bus.cfg_ack), 64'd0);
    @(negedge clk);
    cfg_bus.cfg_req = 1'b0;
    cfg_bus.cfg_we  = 1'b0;
    rst_n = 1'b1;
    doRead(8'h00, rv); checkOutput("cnt0_after_reset", 64'(rv), 64'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
